// File: rtl/axi_gpio_pkg.sv
// Shared definitions for the axi_gpio register slave and pin-side core.
package axi_gpio_pkg;

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } core_state_e;

  localparam int GPIO_WIDTH_DEF = 32;

  // Byte offset of the W1C interrupt status register in the slave map.
  localparam logic [7:0] GPIO_ISR_OFFSET = 8'h20;

endpackage

// File: rtl/axi_gpio_core_if.sv
// Register-side bundle between the AXI-Lite register slave (master) and the pin core (slave).
interface axi_gpio_core_if #(
  parameter int W = axi_gpio_pkg::GPIO_WIDTH_DEF
);
  logic [W-1:0] ctrl_dout;
  logic [W-1:0] ctrl_dir;
  logic [W-1:0] ctrl_ien;
  logic [W-1:0] ctrl_irq_pol;
  logic         ctrl_gie;
  logic         irq_clr_valid;
  logic [W-1:0] irq_clr_mask;
  logic [W-1:0] gpio_in_val;
  logic [W-1:0] irq_status;
  logic         irq;

  modport master (
    output ctrl_dout, ctrl_dir, ctrl_ien, ctrl_irq_pol, ctrl_gie,
    output irq_clr_valid, irq_clr_mask,
    input  gpio_in_val, irq_status, irq
  );

  modport slave (
    input  ctrl_dout, ctrl_dir, ctrl_ien, ctrl_irq_pol, ctrl_gie,
    input  irq_clr_valid, irq_clr_mask,
    output gpio_in_val, irq_status, irq
  );
endinterface

// File: rtl/gpio_debounce.sv
// One GPIO bit: input synchroniser, mismatch counter and debounced stable flop.
module gpio_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pin_i,
  input  logic prime_i,
  output logic val_o,
  output logic upd_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   val_q, val_d;
  logic                   upd_q, upd_d;
  logic                   sync;

  assign sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin_i};
    cnt_d  = cnt_q;
    val_d  = val_q;
    upd_d  = 1'b0;
    if (prime_i) begin
      // Load what the last sync stage is about to hold, so val matches sync when priming ends.
      val_d = sync_q[SYNC_STAGES-2];
      cnt_d = '0;
    end else if (sync == val_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      val_d = sync;
      cnt_d = '0;
      upd_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '0;
      cnt_q  <= '0;
      val_q  <= 1'b0;
      upd_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      val_q  <= val_d;
      upd_q  <= upd_d;
    end
  end

  assign val_o = val_q;
  assign upd_o = upd_q;
endmodule

// File: rtl/axi_gpio_core.sv
// Pin-side GPIO engine: output/tri-state registers, debounced inputs, edge status and level irq.
module axi_gpio_core
  import axi_gpio_pkg::*;
#(
  parameter int GPIO_WIDTH      = GPIO_WIDTH_DEF,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  axi_gpio_core_if.slave        regs,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  output logic [GPIO_WIDTH-1:0] gpio_o,
  output logic [GPIO_WIDTH-1:0] gpio_t
);
  localparam int PW = $clog2(SYNC_STAGES + 1);
  localparam logic [PW-1:0] PRIME_LAST = PW'(SYNC_STAGES - 1);

  core_state_e           state_q, state_d;
  logic [PW-1:0]         prime_cnt_q, prime_cnt_d;
  logic                  prime;
  logic [GPIO_WIDTH-1:0] in_val, upd;
  logic [GPIO_WIDTH-1:0] set, clr;
  logic [GPIO_WIDTH-1:0] status_q, status_d;
  logic [GPIO_WIDTH-1:0] dout_q, tri_q;
  logic                  irq_q, irq_d;

  always_comb begin
    state_d     = state_q;
    prime_cnt_d = prime_cnt_q;
    unique case (state_q)
      ST_PRIME: begin
        if (prime_cnt_q == PRIME_LAST) begin
          state_d     = ST_RUN;
          prime_cnt_d = '0;
        end else begin
          prime_cnt_d = prime_cnt_q + 1'b1;
        end
      end
      ST_RUN: state_d = ST_RUN;
      default: state_d = ST_PRIME;
    endcase
  end

  assign prime = (state_q == ST_PRIME);

  for (genvar b = 0; b < GPIO_WIDTH; b++) begin : g_bit
    gpio_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db (
      .clk_i   (s_axi_aclk),
      .rst_ni  (s_axi_aresetn),
      .pin_i   (gpio_i[b]),
      .prime_i (prime),
      .val_o   (in_val[b]),
      .upd_o   (upd[b])
    );
  end

  // upd marks the cycle right after a debounced change; the new level selects rising/falling.
  assign set      = upd & ~(in_val ^ regs.ctrl_irq_pol) & regs.ctrl_ien & ~regs.ctrl_dir;
  assign clr      = regs.irq_clr_valid ? regs.irq_clr_mask : '0;
  assign status_d = (status_q & ~clr) | set;
  assign irq_d    = regs.ctrl_gie & (|(status_q & regs.ctrl_ien));

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      state_q     <= ST_PRIME;
      prime_cnt_q <= '0;
      status_q    <= '0;
      irq_q       <= 1'b0;
      dout_q      <= '0;
      tri_q       <= '1;
    end else begin
      state_q     <= state_d;
      prime_cnt_q <= prime_cnt_d;
      status_q    <= status_d;
      irq_q       <= irq_d;
      dout_q      <= regs.ctrl_dout;
      tri_q       <= ~regs.ctrl_dir;
    end
  end

  assign gpio_o           = dout_q;
  assign gpio_t           = tri_q;
  assign regs.gpio_in_val = in_val;
  assign regs.irq_status  = status_q;
  assign regs.irq         = irq_q;
endmodule

// File: tb/tb_axi_gpio_core.sv
// Directed self-checking bench for axi_gpio_core (8 bits, 2 sync stages, 4-cycle debounce).
module tb_axi_gpio_core;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] pins;
  logic [W-1:0] gpio_o, gpio_t;
  int           n_checks = 0;
  int           n_fail = 0;

  axi_gpio_core_if #(.W(W)) rif ();

  axi_gpio_core #(
    .GPIO_WIDTH      (W),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .regs          (rif),
    .gpio_i        (pins),
    .gpio_o        (gpio_o),
    .gpio_t        (gpio_t)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    pins = 8'hA5;
    rst_n = 1'b0;
    rif.ctrl_dout = '0; rif.ctrl_dir = '0; rif.ctrl_ien = '0; rif.ctrl_irq_pol = '0;
    rif.ctrl_gie = 1'b0; rif.irq_clr_valid = 1'b0; rif.irq_clr_mask = '0;
    tick(3);
    n_checks++; if (gpio_t !== 8'hFF) begin n_fail++; $display("FAIL reset_gpio_t got=%h exp=ff", gpio_t); end
    n_checks++; if (gpio_o !== 8'h00) begin n_fail++; $display("FAIL reset_gpio_o got=%h exp=00", gpio_o); end
    n_checks++; if (rif.gpio_in_val !== 8'h00) begin n_fail++; $display("FAIL reset_in_val got=%h exp=00", rif.gpio_in_val); end
    n_checks++; if (rif.irq_status !== 8'h00 || rif.irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq status=%h irq=%b exp=00/0", rif.irq_status, rif.irq); end
    rst_n = 1'b1;
    tick(2);
    n_checks++; if (rif.gpio_in_val !== 8'hA5) begin n_fail++; $display("FAIL prime_in_val got=%h exp=a5", rif.gpio_in_val); end
    tick(8);
    n_checks++; if (rif.gpio_in_val !== 8'hA5 || rif.irq_status !== 8'h00) begin n_fail++; $display("FAIL post_prime in_val=%h status=%h exp=a5/00", rif.gpio_in_val, rif.irq_status); end
  endtask

  task automatic test_output();
    rif.ctrl_dir = 8'h0F;
    rif.ctrl_dout = 8'h55;
    #1;
    n_checks++; if (gpio_o !== 8'h00) begin n_fail++; $display("FAIL out_latency gpio_o got=%h exp=00", gpio_o); end
    tick(1);
    n_checks++; if (gpio_t !== 8'hF0) begin n_fail++; $display("FAIL out_gpio_t got=%h exp=f0", gpio_t); end
    n_checks++; if (gpio_o !== 8'h55) begin n_fail++; $display("FAIL out_gpio_o got=%h exp=55", gpio_o); end
  endtask

  task automatic test_glitch();
    bit seen = 1'b0;
    pins = 8'hA4;
    tick(10);
    n_checks++; if (rif.gpio_in_val !== 8'hA4) begin n_fail++; $display("FAIL settle_a4 got=%h exp=a4", rif.gpio_in_val); end
    pins[0] = 1'b1;
    tick(3);
    pins[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (rif.gpio_in_val[0] !== 1'b0) seen = 1'b1;
    end
    n_checks++; if (seen) begin n_fail++; $display("FAIL glitch_rejected got=1 exp=0"); end
  endtask

  task automatic test_debounce_latency();
    pins[0] = 1'b1;
    tick(5);
    n_checks++; if (rif.gpio_in_val[0] !== 1'b0) begin n_fail++; $display("FAIL latency_5 got=%b exp=0", rif.gpio_in_val[0]); end
    tick(1);
    n_checks++; if (rif.gpio_in_val[0] !== 1'b1) begin n_fail++; $display("FAIL latency_6 got=%b exp=1", rif.gpio_in_val[0]); end
  endtask

  task automatic test_irq();
    rif.ctrl_dir = 8'h00;
    rif.ctrl_ien = 8'h10;
    rif.ctrl_irq_pol = 8'h10;
    rif.ctrl_gie = 1'b1;
    tick(2);
    pins[4] = 1'b1;
    tick(6);
    n_checks++; if (rif.gpio_in_val[4] !== 1'b1 || rif.irq_status !== 8'h00) begin n_fail++; $display("FAIL irq_edge in_val4=%b status=%h exp=1/00", rif.gpio_in_val[4], rif.irq_status); end
    tick(1);
    n_checks++; if (rif.irq_status !== 8'h10 || rif.irq !== 1'b0) begin n_fail++; $display("FAIL irq_status status=%h irq=%b exp=10/0", rif.irq_status, rif.irq); end
    tick(1);
    n_checks++; if (rif.irq !== 1'b1) begin n_fail++; $display("FAIL irq_level got=%b exp=1", rif.irq); end
    rif.irq_clr_valid = 1'b1;
    rif.irq_clr_mask = 8'h10;
    tick(1);
    rif.irq_clr_valid = 1'b0;
    n_checks++; if (rif.irq_status !== 8'h00 || rif.irq !== 1'b1) begin n_fail++; $display("FAIL w1c status=%h irq=%b exp=00/1", rif.irq_status, rif.irq); end
    tick(1);
    n_checks++; if (rif.irq !== 1'b0) begin n_fail++; $display("FAIL irq_drop got=%b exp=0", rif.irq); end
  endtask

  task automatic test_set_wins();
    pins[4] = 1'b0;
    tick(8);
    n_checks++; if (rif.gpio_in_val[4] !== 1'b0 || rif.irq_status !== 8'h00) begin n_fail++; $display("FAIL falling_ignored in_val4=%b status=%h exp=0/00", rif.gpio_in_val[4], rif.irq_status); end
    pins[4] = 1'b1;
    tick(6);
    n_checks++; if (rif.gpio_in_val[4] !== 1'b1) begin n_fail++; $display("FAIL rise2 got=%b exp=1", rif.gpio_in_val[4]); end
    rif.irq_clr_valid = 1'b1;
    rif.irq_clr_mask = 8'h10;
    tick(1);
    rif.irq_clr_valid = 1'b0;
    n_checks++; if (rif.irq_status !== 8'h10) begin n_fail++; $display("FAIL set_wins got=%h exp=10", rif.irq_status); end
    tick(1);
    n_checks++; if (rif.irq !== 1'b1) begin n_fail++; $display("FAIL set_wins_irq got=%b exp=1", rif.irq); end
    rif.ctrl_ien = 8'h00;
    tick(1);
    n_checks++; if (rif.irq !== 1'b0 || rif.irq_status !== 8'h10) begin n_fail++; $display("FAIL ien_mask irq=%b status=%h exp=0/10", rif.irq, rif.irq_status); end
    rif.irq_clr_valid = 1'b1;
    tick(1);
    rif.irq_clr_valid = 1'b0;
    rif.ctrl_ien = 8'h10;
    n_checks++; if (rif.irq_status !== 8'h00) begin n_fail++; $display("FAIL clear2 got=%h exp=00", rif.irq_status); end
  endtask

  task automatic test_reset_midcount();
    bit seen = 1'b0;
    rif.ctrl_ien = 8'h04;
    rif.ctrl_irq_pol = 8'h00;
    tick(1);
    pins[2] = 1'b0;
    tick(4);
    rst_n = 1'b0;
    tick(2);
    n_checks++; if (gpio_t !== 8'hFF || rif.irq_status !== 8'h00) begin n_fail++; $display("FAIL midreset gpio_t=%h status=%h exp=ff/00", gpio_t, rif.irq_status); end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (rif.irq_status !== 8'h00 || rif.irq !== 1'b0) seen = 1'b1;
    end
    n_checks++; if (seen) begin n_fail++; $display("FAIL midreset_no_irq got=set exp=clear"); end
    n_checks++; if (rif.gpio_in_val !== 8'hB1) begin n_fail++; $display("FAIL midreset_in_val got=%h exp=b1", rif.gpio_in_val); end
  endtask

  initial begin
    test_reset();
    test_output();
    test_glitch();
    test_debounce_latency();
    test_irq();
    test_set_wins();
    test_reset_midcount();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
